// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium keystream consumer.
// Contents: controller state type, default warm-up length, default data word width.
package trivium_pkg;

   typedef enum logic [1:0] {
      StWarm,
      StFill,
      StHave,
      StOut
   } state_e;

   // Generator output bits discarded after every reset before the keystream is usable.
   localparam int unsigned TRIVIUM_WARMUP = 1152;
   localparam int unsigned KS_BYTE_W      = 8;

endpackage

// File: rtl/trivium_stream_xor_if.sv
// Plaintext-in / ciphertext-out handshake bundle of trivium_stream_xor.
//   in_valid/in_ready/in_data    : plaintext word, valid/ready
//   out_valid/out_ready/out_data : ciphertext word, valid/ready
// master: the byte-oriented data path (sources plaintext, sinks ciphertext).
// slave : the cipher block.
interface trivium_stream_xor_if #(
   parameter int unsigned BYTE_W = 8
) ();

   logic              in_valid;
   logic              in_ready;
   logic [BYTE_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [BYTE_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/ks_byte_collector.sv
// Requests BYTE_W keystream bits from the generator and packs them LSB-first.
//   clk, rst  : clock, synchronous active-low reset
//   fill      : controller is in the fill phase
//   ks_bit    : generator output, valid the cycle after the enable that produced it
//   issue     : request one more bit from the generator this cycle
//   byte_done : last bit of the word is captured at this clock edge
//   ks_byte   : packed keystream word, first bit in bit 0
module ks_byte_collector #(
   parameter int unsigned BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill,
   input  logic              ks_bit,
   output logic              issue,
   output logic              byte_done,
   output logic [BYTE_W-1:0] ks_byte
);

   localparam int unsigned     CntW    = $clog2(BYTE_W + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(BYTE_W);
   localparam logic [CntW-1:0] CntLast = CntW'(BYTE_W - 1);

   logic [CntW-1:0]   issue_cnt_q, issue_cnt_d;
   logic [CntW-1:0]   cap_cnt_q, cap_cnt_d;
   logic              ks_en_d_q, ks_en_d_d;
   logic [BYTE_W-1:0] shift_q, shift_d;

   always_comb begin
      issue       = fill && (issue_cnt_q < CntFull);
      byte_done   = ks_en_d_q && (cap_cnt_q == CntLast);
      // Only fill-phase requests are tracked, so a bit still in flight from
      // the last warm-up enable is never captured.
      ks_en_d_d   = issue;
      issue_cnt_d = issue_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      shift_d     = shift_q;
      if (issue) begin
         issue_cnt_d = issue_cnt_q + CntW'(1);
      end
      if (ks_en_d_q) begin
         // Shift in at the MSB so the first bit ends up in bit 0.
         shift_d   = {ks_bit, shift_q[BYTE_W-1:1]};
         cap_cnt_d = cap_cnt_q + CntW'(1);
      end
      if (byte_done) begin
         issue_cnt_d = '0;
         cap_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         issue_cnt_q <= '0;
         cap_cnt_q   <= '0;
         ks_en_d_q   <= 1'b0;
         shift_q     <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         ks_en_d_q   <= ks_en_d_d;
         shift_q     <= shift_d;
      end
   end

   assign ks_byte = shift_q;

endmodule

// File: rtl/trivium_stream_xor.sv
// XORs plaintext words with the Trivium keystream (encrypts and decrypts alike).
//   clk, rst : clock, synchronous active-low reset shared with the generator
//   ks_en    : generator enable
//   ks_bit   : generator keystream bit (registered in the generator)
//   ks_live  : warm-up finished, held until the next reset
//   bus      : plaintext in / ciphertext out valid-ready bundle
module trivium_stream_xor
   import trivium_pkg::*;
#(
   parameter int unsigned WARMUP_CYCLES = TRIVIUM_WARMUP,
   parameter int unsigned BYTE_W        = KS_BYTE_W
) (
   input  logic                clk,
   input  logic                rst,
   output logic                ks_en,
   input  logic                ks_bit,
   output logic                ks_live,
   trivium_stream_xor_if.slave bus
);

   localparam int unsigned     WarmW    = $clog2(WARMUP_CYCLES + 1);
   localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);

   state_e            state_q, state_d;
   logic [WarmW-1:0]  warm_cnt_q, warm_cnt_d;
   logic              ks_live_q, ks_live_d;
   logic              out_valid_q, out_valid_d;
   logic [BYTE_W-1:0] out_data_q, out_data_d;

   logic              warm_en;
   logic              fill_issue;
   logic              byte_done;
   logic [BYTE_W-1:0] ks_byte;

   ks_byte_collector #(
      .BYTE_W (BYTE_W)
   ) u_collector (
      .clk       (clk),
      .rst       (rst),
      .fill      (state_q == StFill),
      .ks_bit    (ks_bit),
      .issue     (fill_issue),
      .byte_done (byte_done),
      .ks_byte   (ks_byte)
   );

   always_comb begin
      state_d      = state_q;
      warm_cnt_d   = warm_cnt_q;
      ks_live_d    = ks_live_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      warm_en      = 1'b0;
      bus.in_ready = 1'b0;
      unique case (state_q)
         StWarm: begin
            warm_en    = 1'b1;
            warm_cnt_d = warm_cnt_q + WarmW'(1);
            if (warm_cnt_q == WarmLast) begin
               state_d   = StFill;
               ks_live_d = 1'b1;
            end
         end
         StFill: begin
            if (byte_done) begin
               state_d = StHave;
            end
         end
         StHave: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               out_data_d  = bus.in_data ^ ks_byte;
               out_valid_d = 1'b1;
               state_d     = StOut;
            end
         end
         StOut: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StFill;
            end
         end
         default: state_d = StWarm;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StWarm;
         warm_cnt_q  <= '0;
         ks_live_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         warm_cnt_q  <= warm_cnt_d;
         ks_live_q   <= ks_live_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Keep the generator idle while reset is held, even though the state is already WARM.
   assign ks_en         = rst && (warm_en || fill_issue);
   assign ks_live       = ks_live_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule
